mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/risc_pkg.sv | 26 ++
 rtl/rr_pick2.sv | 16 +
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared types for the RISC core data-memory path.
package risc_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } op_dmem_size;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_enum;

    // Address-independent part of a data-memory command.
    typedef struct packed {
        logic                  wen;
        op_dmem_size           size;
        logic                  zero_ex;
        logic [DATA_WIDTH-1:0] wdata;
    } dmem_cmd_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_pick2 (
    input  logic req_0,
    input  logic req_1,
    input  logic last_gnt,
    output logic any_c,
    output logic winner_c
);

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    always_comb begin
        any_c    = req_0 | req_1;
        winner_c = req_1 & (~req_0 | ~last_gnt);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single data RAM port with fixed read latency.
module mem_arbiter
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned MEM_READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic                  wen_0,
    input  logic                  wen_1,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  op_dmem_size           size_0,
    input  op_dmem_size           size_1,
    input  logic                  zero_ex_0,
    input  logic                  zero_ex_1,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic                  rvalid_0,
    output logic                  rvalid_1,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic                  mem_zero_ex,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output op_dmem_size           mem_size,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    arb_state_enum        state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 owner, owner_nxt;
    logic                 last_gnt, last_gnt_nxt;
    logic                 any_req_c;
    logic                 winner_c;
    dmem_cmd_t            cmd_0, cmd_1, win_cmd;
    logic [ADDR_WIDTH-1:0] win_addr;

    assign cmd_0 = '{wen: wen_0, size: size_0, zero_ex: zero_ex_0, wdata: wdata_0};
    assign cmd_1 = '{wen: wen_1, size: size_1, zero_ex: zero_ex_1, wdata: wdata_1};

    rr_pick2 u_pick (
        .req_0    (req_0),
        .req_1    (req_1),
        .last_gnt (last_gnt),
        .any_c    (any_req_c),
        .winner_c (winner_c)
    );

    // State register; requester 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state    <= ARB_IDLE;
            cnt      <= '0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Issue/return decode; every output is held at zero while reset is asserted.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        owner_nxt    = owner;
        last_gnt_nxt = last_gnt;
        gnt_0        = 1'b0;
        gnt_1        = 1'b0;
        rvalid_0     = 1'b0;
        rvalid_1     = 1'b0;
        rdata_0      = '0;
        rdata_1      = '0;
        mem_req      = 1'b0;
        mem_wen      = 1'b0;
        mem_zero_ex  = 1'b0;
        mem_addr     = '0;
        mem_size     = SIZE_BYTE;
        mem_wr_data  = '0;
        win_cmd      = winner_c ? cmd_1 : cmd_0;
        win_addr     = winner_c ? addr_1 : addr_0;

        if (res_n) begin
            case (state)
                ARB_IDLE: begin
                    if (any_req_c) begin
                        mem_req      = 1'b1;
                        mem_wen      = win_cmd.wen;
                        mem_zero_ex  = win_cmd.zero_ex;
                        mem_addr     = win_addr;
                        mem_size     = win_cmd.size;
                        mem_wr_data  = win_cmd.wdata;
                        gnt_0        = ~winner_c;
                        gnt_1        = winner_c;
                        last_gnt_nxt = winner_c;
                        if (!win_cmd.wen) begin
                            owner_nxt = winner_c;
                            cnt_nxt   = CNT_WIDTH'(1);
                            state_nxt = ARB_WAIT;
                        end
                    end
                end
                ARB_WAIT: begin
                    if (cnt == CNT_WIDTH'(MEM_READ_LAT)) begin
                        rvalid_0  = ~owner;
                        rvalid_1  = owner;
                        rdata_0   = owner ? '0 : mem_rd_data;
                        rdata_1   = owner ? mem_rd_data : '0;
                        cnt_nxt   = '0;
                        state_nxt = ARB_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_WIDTH'(1);
                    end
                end
                default: state_nxt = ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: instance 0 runs MEM_READ_LAT=1, instance 1 runs MEM_READ_LAT=3.
module tb_mem_arbiter;
    import risc_pkg::*;

    localparam int unsigned AW = 16;
    localparam int NI = 2;

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          res_n [NI];
    logic          req0 [NI], req1 [NI], wen0 [NI], wen1 [NI], zx0 [NI], zx1 [NI];
    logic [AW-1:0] addr0 [NI], addr1 [NI];
    op_dmem_size   size0 [NI], size1 [NI];
    logic [31:0]   wd0 [NI], wd1 [NI];
    logic          gnt0 [NI], gnt1 [NI], rv0 [NI], rv1 [NI];
    logic [31:0]   rd0 [NI], rd1 [NI];
    logic          m_req [NI], m_wen [NI], m_zx [NI];
    logic [AW-1:0] m_addr [NI];
    op_dmem_size   m_size [NI];
    logic [31:0]   m_wd [NI], m_rd [NI];
    logic [31:0]   ram [NI][64];
    logic [31:0]   pipe [NI][3];

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int pushes = 0;
    int rv_seen = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_arbiter #(.ADDR_WIDTH(AW), .MEM_READ_LAT((g == 0) ? 1 : 3)) u_dut (
            .clk(clk), .res_n(res_n[g]),
            .req_0(req0[g]), .req_1(req1[g]), .wen_0(wen0[g]), .wen_1(wen1[g]),
            .addr_0(addr0[g]), .addr_1(addr1[g]), .size_0(size0[g]), .size_1(size1[g]),
            .zero_ex_0(zx0[g]), .zero_ex_1(zx1[g]), .wdata_0(wd0[g]), .wdata_1(wd1[g]),
            .gnt_0(gnt0[g]), .gnt_1(gnt1[g]), .rvalid_0(rv0[g]), .rvalid_1(rv1[g]),
            .rdata_0(rd0[g]), .rdata_1(rd1[g]),
            .mem_req(m_req[g]), .mem_wen(m_wen[g]), .mem_zero_ex(m_zx[g]),
            .mem_addr(m_addr[g]), .mem_size(m_size[g]), .mem_wr_data(m_wd[g]),
            .mem_rd_data(m_rd[g])
        );
        assign m_rd[g] = pipe[g][(g == 0) ? 0 : 2];
    end

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // RAM model: the RAM itself performs the size/sign extension.
    function automatic logic [31:0] ram_rd(int k, logic [AW-1:0] a, op_dmem_size s, logic zx);
        logic [31:0] w;
        logic [31:0] sh;
        w  = ram[k][a[7:2]];
        sh = w >> {a[1:0], 3'b000};
        case (s)
            SIZE_BYTE: return zx ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: return zx ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:   return w;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            for (int s = 2; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
            pipe[k][0] <= (m_req[k] && !m_wen[k]) ? ram_rd(k, m_addr[k], m_size[k], m_zx[k]) : 32'h0;
            if (m_req[k] && m_wen[k]) ram[k][m_addr[k][7:2]] = m_wd[k];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol invariants every cycle, scoreboard pop on each rvalid.
    always @(negedge clk) begin
        int   p;
        logic bad;
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            bad = (gnt0[k] && gnt1[k]) || (rv0[k] && rv1[k]) ||
                  ((gnt0[k] || gnt1[k]) && (rv0[k] || rv1[k])) ||
                  ((gnt0[k] || gnt1[k]) != m_req[k]) ||
                  (!rv0[k] && rd0[k] != 32'h0) || (!rv1[k] && rd1[k] != 32'h0) ||
                  (!m_req[k] && (m_wen[k] || m_zx[k] || m_addr[k] != '0 ||
                                 m_size[k] != SIZE_BYTE || m_wd[k] != 32'h0));
            chk("invariants", 32'(bad), 32'h0);
            if (rv0[k] || rv1[k]) begin
                rv_seen++;
                p = rv1[k] ? 1 : 0;
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("rv_inst", k, e.inst);
                    chk("rv_port", p, e.port);
                    chk("rv_cycle", cyc, e.cyc);
                    chk("rv_data", (p == 1) ? rd1[k] : rd0[k], e.data);
                    chk("rv_other_rdata", (p == 1) ? rd0[k] : rd1[k], 32'h0);
                end
            end
        end
    end

    task automatic drive(int k, int p, logic r, logic w, logic [AW-1:0] a,
                         op_dmem_size s, logic zx, logic [31:0] d);
        if (p == 0) begin
            req0[k] = r; wen0[k] = w; addr0[k] = a; size0[k] = s; zx0[k] = zx; wd0[k] = d;
        end else begin
            req1[k] = r; wen1[k] = w; addr1[k] = a; size1[k] = s; zx1[k] = zx; wd1[k] = d;
        end
    endtask

    function automatic logic get_gnt(int k, int p);
        return (p == 0) ? gnt0[k] : gnt1[k];
    endfunction

    // Called just after a rising edge. gcyc: grant cycle, -1 withdrawn, -2 timed out.
    task automatic issue(int k, int p, logic w, logic [AW-1:0] a, op_dmem_size s, logic zx,
                         logic [31:0] d, bit expect_rv, bit use_model, logic [31:0] exp_d,
                         int wd_pct, output int gcyc);
        exp_t e;
        gcyc = -2;
        drive(k, p, 1'b1, w, a, s, zx, d);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (get_gnt(k, p)) begin
                gcyc = cyc;
                if (!w && expect_rv) begin
                    e.inst = k; e.port = p; e.cyc = cyc + lat(k);
                    e.data = use_model ? ram_rd(k, a, s, zx) : exp_d;
                    q.push_back(e);
                    pushes++;
                end
            end
            @(posedge clk); #1;
            if (gcyc >= 0) break;
            if (wd_pct > 0 && int'($urandom_range(0, 99)) < wd_pct) begin
                gcyc = -1;
                break;
            end
        end
        drive(k, p, 1'b0, 1'b0, '0, SIZE_BYTE, 1'b0, 32'h0);
    endtask

    task automatic do_reset(int k);
        res_n[k] = 1'b0;
        @(posedge clk); #1;
        res_n[k] = 1'b1;
    endtask

    task automatic soak_port(int k, int p, int n);
        int            g;
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            w = ($urandom_range(0, 1) == 1);
            a = AW'($urandom_range(16, 31) << 2);
            d = $urandom;
            issue(k, p, w, a, SIZE_WORD, 1'b0, d, 1'b1, 1'b1, 32'h0, 20, g);
            chk("soak_no_timeout", 32'(g == -2), 32'h0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b, g, g00, g01, g10, g11;
        for (int k = 0; k < NI; k++) begin
            res_n[k] = 1'b0;
            drive(k, 0, 1'b0, 1'b0, '0, SIZE_BYTE, 1'b0, 32'h0);
            drive(k, 1, 1'b0, 1'b0, '0, SIZE_BYTE, 1'b0, 32'h0);
            for (int i = 0; i < 64; i++) ram[k][i] = 32'h0;
        end
        ram[0][4]  = 32'hDEADBEEF;
        ram[0][12] = 32'h0000_8000;
        ram[1][16] = 32'h1234_5678;
        ram[1][18] = 32'hCAFE_F00D;

        // Requests held during reset must not be granted.
        drive(0, 0, 1'b1, 1'b0, 16'h0010, SIZE_WORD, 1'b0, 32'h0);
        drive(1, 1, 1'b1, 1'b1, 16'h0020, SIZE_WORD, 1'b0, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reset_strobes", {26'h0, gnt0[k], gnt1[k], rv0[k], rv1[k], m_req[k], m_wen[k]}, 32'h0);
            chk("reset_rdata", rd0[k] | rd1[k], 32'h0);
        end
        @(posedge clk); #1;
        drive(0, 0, 1'b0, 1'b0, '0, SIZE_BYTE, 1'b0, 32'h0);
        drive(1, 1, 1'b0, 1'b0, '0, SIZE_BYTE, 1'b0, 32'h0);
        res_n[0] = 1'b1;
        res_n[1] = 1'b1;

        // LAT=1 single word read.
        b = cyc;
        issue(0, 0, 1'b0, 16'h0010, SIZE_WORD, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 0, g);
        chk("lat1_read_gnt_cycle", g, b);
        repeat (3) begin @(posedge clk); #1; end
        chk("lat1_read_drained", q.size(), 0);

        // Back-to-back writes from both requesters alternate 0,1,0,1.
        do_reset(0);
        b = cyc;
        fork
            begin
                issue(0, 0, 1'b1, 16'h0020, SIZE_WORD, 1'b0, 32'hA000_0001, 1'b0, 1'b0, 32'h0, 0, g00);
                issue(0, 0, 1'b1, 16'h0024, SIZE_WORD, 1'b0, 32'hA000_0002, 1'b0, 1'b0, 32'h0, 0, g01);
            end
            begin
                issue(0, 1, 1'b1, 16'h0028, SIZE_WORD, 1'b0, 32'hB000_0001, 1'b0, 1'b0, 32'h0, 0, g10);
                issue(0, 1, 1'b1, 16'h002C, SIZE_WORD, 1'b0, 32'hB000_0002, 1'b0, 1'b0, 32'h0, 0, g11);
            end
        join
        chk("wr_gnt_order_0", g00, b);
        chk("wr_gnt_order_1", g10, b + 1);
        chk("wr_gnt_order_2", g01, b + 2);
        chk("wr_gnt_order_3", g11, b + 3);
        chk("wr_ram_8", ram[0][8], 32'hA000_0001);
        chk("wr_ram_9", ram[0][9], 32'hA000_0002);
        chk("wr_ram_10", ram[0][10], 32'hB000_0001);
        chk("wr_ram_11", ram[0][11], 32'hB000_0002);

        // Sub-word reads: sign- and zero-extension done by the RAM, routed to owner only.
        issue(0, 1, 1'b0, 16'h0031, SIZE_BYTE, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80, 0, g);
        issue(0, 0, 1'b0, 16'h0031, SIZE_BYTE, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 0, g);
        issue(0, 0, 1'b0, 16'h0030, SIZE_HALF, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_8000, 0, g);
        repeat (3) begin @(posedge clk); #1; end

        // LAT=3: read on requester 1 blocks requester 0 until T+4.
        b = cyc;
        fork
            issue(1, 1, 1'b0, 16'h0040, SIZE_WORD, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 0, g10);
            begin
                @(posedge clk); #1;
                issue(1, 0, 1'b1, 16'h0044, SIZE_WORD, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0, 0, g00);
            end
        join
        chk("lat3_read_gnt", g10, b);
        chk("lat3_blocked_gnt", g00, b + 4);
        chk("lat3_write_ram", ram[1][17], 32'hA5A5_0001);

        // Reset one cycle into a LAT=3 read discards it; next request granted at once.
        b = cyc;
        issue(1, 0, 1'b0, 16'h0040, SIZE_WORD, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, g);
        chk("abort_read_gnt", g, b);
        res_n[1] = 1'b0;
        @(posedge clk); #1;
        res_n[1] = 1'b1;
        b = cyc;
        issue(1, 0, 1'b0, 16'h0048, SIZE_WORD, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D, 0, g);
        chk("post_reset_gnt", g, b);
        repeat (5) begin @(posedge clk); #1; end
        chk("directed_drained", q.size(), 0);

        // Random request/withdraw soak on both latencies.
        for (int k = 0; k < NI; k++) begin
            fork
                soak_port(k, 0, 30);
                soak_port(k, 1, 30);
            join
            repeat (6) begin @(posedge clk); #1; end
        end
        chk("final_queue_empty", q.size(), 0);
        chk("rvalid_count", rv_seen, pushes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
